// File: rtl/if_id_fetch.sv
// Instruction fetch stage with IF/ID pipeline register, one-entry skid buffer
// and redirect handling that drains an outstanding memory request before refetching.
module if_id_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [15:0] imm16_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 16;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  ifid_t           skid_q, skid_d;
  ifid_t           out_q, out_d;
  logic            valid_q, valid_d;

  logic            req_c;
  logic            ack_c;
  logic [XLEN-1:0] pc_inc_c;
  logic [XLEN-1:0] redir_pc_c;
  ifid_t           fetched_c;

  // Request is dropped while the skid holds an instruction and during reset;
  // an ack seen without a request is ignored.
  assign req_c      = !rst_i && (state_q != FULL);
  assign ack_c      = imem_ack_i && req_c;
  assign pc_inc_c   = pc_q + PC_STEP;
  assign redir_pc_c = redirect_pc_i & ALIGN_MASK;
  assign fetched_c  = {imem_data_i, pc_inc_c};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    skid_d  = skid_q;
    out_d   = out_q;
    valid_d = valid_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          if (ack_c) begin
            pc_d = redir_pc_c;
          end else begin
            tgt_d   = redir_pc_c;
            state_d = DRAIN;
          end
        end else if (ack_c) begin
          pc_d = pc_inc_c;
          if (stall_i) begin
            skid_d  = fetched_c;
            state_d = FULL;
          end else begin
            out_d   = fetched_c;
            valid_d = 1'b1;
          end
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end

      FULL: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          pc_d    = redir_pc_c;
          state_d = FETCH;
        end else if (!stall_i) begin
          out_d   = skid_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        // Address stays on the abandoned fetch until memory answers it.
        valid_d = 1'b0;
        if (ack_c) begin
          pc_d    = redirect_i ? redir_pc_c : tgt_q;
          state_d = FETCH;
        end else if (redirect_i) begin
          tgt_d = redir_pc_c;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC & ALIGN_MASK;
      tgt_q   <= '0;
      skid_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      skid_q  <= skid_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req_o  = req_c;
  assign imem_addr_o = pc_q;
  assign instr_o     = out_q.instr;
  assign imm16_o     = out_q.instr[IMM_W-1:0];
  assign pc_plus4_o  = out_q.pc_plus4;
  assign valid_o     = valid_q;

endmodule

// File: doc/if_id_fetch.md
IF_ID_FETCH -- requirements
Module: if_id_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 clk_i  input  1: single clock; all state updates on rising edge.
REQ-003 rst_i  input  1: synchronous, active-high reset.
REQ-004 imem_req_o  output  1: instruction memory request, level.
REQ-005 imem_addr_o  output  32: fetch address, word aligned.
REQ-006 imem_ack_i  input  1: one-cycle response strobe; only asserted while imem_req_o=1.
REQ-007 imem_data_i  input  32: instruction word, valid when imem_ack_i=1.
REQ-008 stall_i  input  1: downstream (decode) cannot accept; IF/ID outputs hold.
REQ-009 redirect_i  input  1: branch/jump taken; flush and refetch.
REQ-010 redirect_pc_i  input  32: new PC, sampled when redirect_i=1.
REQ-011 instr_o  output  32: IF/ID instruction register.
REQ-012 imm16_o  output  16: equals instr_o[15:0]; drives the sign-extend stage.
REQ-013 pc_plus4_o  output  32: address of instr_o plus 4.
REQ-014 valid_o  output  1: instr_o/pc_plus4_o hold a real instruction.

Function
REQ-015 Internal state: pc (32), skid buffer {instr, pc+4} (64), FSM with states FETCH, FULL, DRAIN.
REQ-016 FETCH: imem_req_o=1, imem_addr_o=pc; addr and req stable until imem_ack_i.
REQ-017 FETCH, ack=1, stall_i=0: instr_o<=imem_data_i, pc_plus4_o<=pc+4, valid_o<=1, pc<=pc+4; stay FETCH (back-to-back acks give one instruction per cycle).
REQ-018 FETCH, ack=1, stall_i=1: outputs hold; data and pc+4 written to skid; pc<=pc+4; go FULL.
REQ-019 FETCH, ack=0, stall_i=0: valid_o<=0 (bubble); instr_o/pc_plus4_o contents don't-care but held.
REQ-020 FETCH, ack=0, stall_i=1: all outputs hold.
REQ-021 FULL: imem_req_o=0; while stall_i=1 hold everything; when stall_i=0, outputs<=skid, valid_o<=1, go FETCH.
REQ-022 Redirect has highest priority over stall and ack: next cycle valid_o=0, skid invalidated, pc<={redirect_pc_i[31:2],2'b00}.
REQ-023 Redirect in FETCH with ack=0: go DRAIN; DRAIN keeps imem_req_o=1 and old address until ack, discards the data, then goes FETCH at redirected pc.
REQ-024 Redirect in FETCH with ack=1, or in FULL: data discarded, go FETCH directly.
REQ-025 Redirect in DRAIN: pc updated to newest target; remain DRAIN (or FETCH if ack same cycle).
REQ-026 pc+4 arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 imm16_o is combinationally instr_o[15:0]; no added latency.
REQ-028 Latency: instruction appears on instr_o the cycle after its ack when not stalled.

Reset
REQ-029 While rst_i=1 at a clock edge: pc<=RESET_PC, state<=FETCH, skid invalid, instr_o<=0, pc_plus4_o<=0, valid_o<=0.
REQ-030 imem_req_o=0 during any cycle with rst_i=1; first request issued in the cycle after reset deasserts.
REQ-031 Reset mid-transaction (DRAIN/FETCH outstanding) abandons it; a late ack arriving with req=0 is ignored.

Verification
REQ-032 Reset, memory acks every cycle with data=addr^32'hA5A5_0000: instr_o sequence 32'hA5A5_0000, 32'hA5A5_0004, ...; pc_plus4_o = 4, 8, ...; imm16_o tracks instr_o[15:0].
REQ-033 Ack latency 3 cycles: valid_o low 3 cycles, high 1, repeating; imem_addr_o constant during each wait.
REQ-034 stall_i high 4 cycles while acks continue: outputs frozen, exactly one skid capture, req low in FULL; on release no instruction lost or duplicated.
REQ-035 redirect_i with redirect_pc_i=32'h0000_0103 during outstanding fetch of 0x10: DRAIN until ack, data discarded, next request addr 32'h0000_0100, valid_o=0 until its ack.
REQ-036 RESET_PC=32'hFFFF_FFFC, ack every cycle: pc_plus4_o=32'h0000_0000 for first instruction, next fetch addr 0.
REQ-037 rst_i asserted in FULL with stall_i=1: next cycle valid_o=0, imem_req_o=0, skid content never appears on outputs.
